// File: rtl/sdram_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : sdram_arbiter
// Purpose : Round-robin two-port arbiter in front of the SDRAM read/write
//           controller; optional completion watchdog via SDRAM_ARB_WDOG_EN.
// Rev     : 1.0
// ----------------------------------------------------------------------------
module sdram_arbiter #(
  parameter int ADDR_W      = 22,
  parameter int DATA_W      = 16,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic              clk_50MHz,
  input  logic              reset,
  input  logic              init_done,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_done,
  output logic              p1_done,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_we,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_done,
  input  logic [DATA_W-1:0] cmd_rdata,
  output logic              arb_err
);

  localparam logic [1:0] WAIT_INIT = 2'd0;
  localparam logic [1:0] IDLE      = 2'd1;
  localparam logic [1:0] ISSUE     = 2'd2;
  localparam logic [1:0] BUSY      = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       owner;
  logic       last_owner;
  logic       any_req;
  logic       pick1;
  logic       accept;
  logic       finish;
  logic       abort;

  assign any_req = p0_req | p1_req;
  // Port 1 wins when alone, or on a tie when port 0 was served last.
  assign pick1   = p1_req & (~p0_req | ~last_owner);
  assign accept  = (state == ISSUE) & cmd_ready & ~abort;
  assign finish  = (state == BUSY) & cmd_done;

`ifdef SDRAM_ARB_WDOG_EN
  localparam int WDOG_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;

  logic [WDOG_W-1:0] wdog_cnt;

  // A real completion in the same cycle as the timeout is honoured.
  assign abort = ((state == ISSUE) || (state == BUSY)) &&
                 (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1)) && !finish;

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      wdog_cnt <= '0;
      arb_err  <= 1'b0;
    end else begin
      arb_err <= abort;
      if (state == IDLE)
        wdog_cnt <= '0;
      else if ((state == ISSUE) || (state == BUSY))
        wdog_cnt <= wdog_cnt + 1'b1;
    end
  end
`else
  logic unused_wdog_cfg;

  assign unused_wdog_cfg = (WDOG_CYCLES > 0);
  assign abort           = 1'b0;
  assign arb_err         = 1'b0;
`endif

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset)
      state <= WAIT_INIT;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_INIT: if (init_done) state_nxt = IDLE;
      IDLE: begin
        if (!init_done)
          state_nxt = WAIT_INIT;
        else if (any_req)
          state_nxt = ISSUE;
      end
      ISSUE: begin
        if (abort)
          state_nxt = IDLE;
        else if (cmd_ready)
          state_nxt = BUSY;
      end
      BUSY: if (finish || abort) state_nxt = IDLE;
      default: state_nxt = WAIT_INIT;
    endcase
  end

  always_comb begin
    cmd_valid = (state == ISSUE);
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      owner      <= 1'b0;
      last_owner <= 1'b1;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      p0_gnt     <= 1'b0;
      p1_gnt     <= 1'b0;
      p0_done    <= 1'b0;
      p1_done    <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
    end else begin
      p0_gnt  <= 1'b0;
      p1_gnt  <= 1'b0;
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      if ((state == IDLE) && init_done && any_req) begin
        owner     <= pick1;
        cmd_we    <= pick1 ? p1_we    : p0_we;
        cmd_addr  <= pick1 ? p1_addr  : p0_addr;
        cmd_wdata <= pick1 ? p1_wdata : p0_wdata;
      end
      if (accept) begin
        p0_gnt     <= ~owner;
        p1_gnt     <= owner;
        last_owner <= owner;
      end
      if (finish || abort) begin
        p0_done <= ~owner;
        p1_done <= owner;
      end
      if (abort)
        last_owner <= owner;
      if (finish && !cmd_we) begin
        if (owner)
          p1_rdata <= cmd_rdata;
        else
          p0_rdata <= cmd_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// Testbench for sdram_arbiter: directed steps, a completion scoreboard and a
// small SDRAM controller responder model.
module tb_sdram_arbiter;
  localparam int ADDR_W      = 22;
  localparam int DATA_W      = 16;
  localparam int WDOG_CYCLES = 16;

  typedef struct packed {
    logic              port;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  logic              clk_50MHz = 1'b0;
  logic              reset     = 1'b1;
  logic              init_done = 1'b0;
  logic              p0_req = 1'b0, p1_req = 1'b0;
  logic              p0_we = 1'b0, p1_we = 1'b0;
  logic [ADDR_W-1:0] p0_addr = '0, p1_addr = '0;
  logic [DATA_W-1:0] p0_wdata = '0, p1_wdata = '0;
  logic              p0_gnt, p1_gnt, p0_done, p1_done;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic              cmd_valid;
  logic              cmd_ready = 1'b1;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_done;
  logic [DATA_W-1:0] cmd_rdata;
  logic              arb_err;

  int checks   = 0;
  int failures = 0;

  exp_t              sb[$];
  exp_t              mon_e;
  bit                gnt_log[$];
  logic [DATA_W-1:0] model_mem [256];
  logic [DATA_W-1:0] last_rd [2];
  bit                bad, seen;
  int                n;

  // Controller responder state
  int                done_delay = 2;
  bit                never_done = 1'b0;
  logic [DATA_W-1:0] ctrl_mem [256];
  logic              pend, pend_we;
  logic [7:0]        pend_a;
  logic [DATA_W-1:0] pend_d;
  int                pend_cnt;

  sdram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WDOG_CYCLES(WDOG_CYCLES)
  ) dut (
    .clk_50MHz(clk_50MHz), .reset(reset), .init_done(init_done),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_done(p0_done), .p1_done(p1_done),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_done(cmd_done),
    .cmd_rdata(cmd_rdata), .arb_err(arb_err)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  always @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      pend      <= 1'b0;
      pend_we   <= 1'b0;
      pend_a    <= '0;
      pend_d    <= '0;
      pend_cnt  <= 0;
      cmd_done  <= 1'b0;
      cmd_rdata <= '0;
    end else begin
      cmd_done <= 1'b0;
      if (!pend) begin
        if (cmd_valid && cmd_ready && !never_done) begin
          pend     <= 1'b1;
          pend_cnt <= done_delay;
          pend_we  <= cmd_we;
          pend_a   <= cmd_addr[7:0];
          pend_d   <= cmd_wdata;
        end
      end else if (pend_cnt <= 1) begin
        pend     <= 1'b0;
        cmd_done <= 1'b1;
        if (pend_we) begin
          ctrl_mem[pend_a] <= pend_d;
          cmd_rdata        <= 16'hDEAD;
        end else begin
          cmd_rdata <= ctrl_mem[pend_a];
        end
      end else begin
        pend_cnt <= pend_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit port, input bit we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata);
    exp_t e;
    e.port = port;
    if (we) begin
      model_mem[addr[7:0]] = wdata;
      e.rdata = last_rd[port];
    end else begin
      e.rdata = model_mem[addr[7:0]];
      last_rd[port] = e.rdata;
    end
    sb.push_back(e);
  endtask

  task automatic drive(input bit port, input bit we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata);
    if (port) begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end
  endtask

  task automatic set_req(input bit port, input bit we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata);
    push_exp(port, we, addr, wdata);
    drive(port, we, addr, wdata);
  endtask

  task automatic wait_gnt(input bit port);
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk_50MHz);
      if ((port ? p1_gnt : p0_gnt) === 1'b1) got = 1'b1;
    end
    if (port) p1_req = 1'b0; else p0_req = 1'b0;
    check(port ? "gnt_p1" : "gnt_p0", 32'(got), 32'd1);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(negedge clk_50MHz);
      #1;
    end
    check("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: logs grants, retires scoreboard entries on each done pulse.
  always @(negedge clk_50MHz) begin
    if (p0_gnt) gnt_log.push_back(1'b0);
    if (p1_gnt) gnt_log.push_back(1'b1);
    if (p0_gnt && p1_gnt) check("dual_gnt", 32'd1, 32'd0);
    if (p0_done || p1_done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done_onehot", 32'(p0_done ^ p1_done), 32'd1);
        check("done_port", 32'(p1_done), 32'(mon_e.port));
        check("done_rdata", 32'(mon_e.port ? p1_rdata : p0_rdata), 32'(mon_e.rdata));
      end
    end
  end

  initial begin
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (2) @(negedge clk_50MHz);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_gnt", 32'({p1_gnt, p0_gnt}), 32'd0);
    check("rst_done", 32'({p1_done, p0_done}), 32'd0);
    check("rst_arb_err", 32'(arb_err), 32'd0);
    check("rst_cmd_fields", 32'({cmd_we, cmd_addr}), 32'd0);
    check("rst_cmd_wdata", 32'(cmd_wdata), 32'd0);
    check("rst_rdata", 32'({p1_rdata, p0_rdata}), 32'd0);

    // Requests held off until init completes
    reset = 1'b0;
    set_req(1'b0, 1'b1, 22'h000010, 16'hCAFE);
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk_50MHz);
      if (cmd_valid || p0_gnt || p1_gnt) bad = 1'b1;
    end
    check("hold_before_init", 32'(bad), 32'd0);
    init_done = 1'b1;
    repeat (2) @(negedge clk_50MHz);
    check("init_cmd_valid", 32'(cmd_valid), 32'd1);
    check("init_cmd_addr", 32'(cmd_addr), 32'h000010);
    check("init_cmd_we", 32'(cmd_we), 32'd1);
    check("init_cmd_wdata", 32'(cmd_wdata), 32'hCAFE);
    wait_gnt(1'b0);
    wait_empty();

    // Write then read back through port 0
    set_req(1'b0, 1'b1, 22'h000020, 16'h5A5A);
    wait_gnt(1'b0);
    wait_empty();
    set_req(1'b0, 1'b0, 22'h000010, 16'h0000);
    wait_gnt(1'b0);
    wait_empty();
    check("p0_read_cafe", 32'(p0_rdata), 32'hCAFE);

    // Slow p1 read; p0 request must wait for it
    done_delay = 20;
    set_req(1'b1, 1'b0, 22'h000020, 16'h0000);
    wait_gnt(1'b1);
    set_req(1'b0, 1'b1, 22'h000040, 16'h1234);
    bad  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_50MHz);
      if (p1_done) seen = 1'b1;
      else if (cmd_valid) bad = 1'b1;
    end
    check("p1_slow_done", 32'(seen), 32'd1);
    check("no_overlap_cmd", 32'(bad), 32'd0);
    check("p0_rdata_kept", 32'(p0_rdata), 32'hCAFE);
    check("p1_read_5a5a", 32'(p1_rdata), 32'h5A5A);
    done_delay = 2;
    wait_gnt(1'b0);
    wait_empty();

    // Reset while BUSY
    done_delay = 20;
    set_req(1'b0, 1'b1, 22'h000050, 16'h7777);
    wait_gnt(1'b0);
    @(negedge clk_50MHz);
    reset = 1'b1;
    sb.delete();
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk_50MHz);
    check("midrst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("midrst_gnt_done", 32'({p1_gnt, p0_gnt, p1_done, p0_done}), 32'd0);
    check("midrst_cmd_fields", 32'({cmd_we, cmd_addr}), 32'd0);
    check("midrst_cmd_wdata", 32'(cmd_wdata), 32'd0);
    check("midrst_rdata", 32'({p1_rdata, p0_rdata}), 32'd0);

    // Restart through WAIT_INIT, then both ports contend for 6 commands
    done_delay = 2;
    gnt_log.delete();
    for (int k = 0; k < 3; k++) begin
      push_exp(1'b0, 1'b1, 22'h000030, 16'hBEEF);
      push_exp(1'b1, 1'b0, 22'h000020, 16'h0000);
    end
    drive(1'b0, 1'b1, 22'h000030, 16'hBEEF);
    drive(1'b1, 1'b0, 22'h000020, 16'h0000);
    reset = 1'b0;
    @(negedge clk_50MHz);
    check("restart_wait_init", 32'(cmd_valid), 32'd0);
    @(negedge clk_50MHz);
    check("restart_cmd_valid", 32'(cmd_valid), 32'd1);
    check("first_tie_p0", 32'(cmd_addr), 32'h000030);
    for (int i = 0; i < 300 && gnt_log.size() < 6; i++) begin
      @(negedge clk_50MHz);
      #1;
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    wait_empty();
    repeat (5) @(negedge clk_50MHz);
    check("rr_gnt_count", 32'(gnt_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++)
      check("rr_gnt_order", 32'(gnt_log[i]), 32'(i % 2));

`ifdef SDRAM_ARB_WDOG_EN
    // Controller never completes: watchdog aborts, then p1 is serviced
    never_done = 1'b1;
    cmd_ready  = 1'b0;
    sb.push_back('{port: 1'b0, rdata: last_rd[0]});
    drive(1'b0, 1'b0, 22'h000010, 16'h0000);
    for (int i = 0; i < 10 && !cmd_valid; i++) @(negedge clk_50MHz);
    n = 0;
    while (!arb_err && n < 40) begin
      @(negedge clk_50MHz);
      n++;
    end
    p0_req = 1'b0;
    check("wdog_latency", 32'(n), 32'(WDOG_CYCLES));
    check("wdog_p0_done", 32'(p0_done), 32'd1);
    never_done = 1'b0;
    cmd_ready  = 1'b1;
    set_req(1'b1, 1'b0, 22'h000010, 16'h0000);
    wait_gnt(1'b1);
    wait_empty();
    check("wdog_p1_read", 32'(p1_rdata), 32'hCAFE);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
